// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM state codes, key indices
// and the (row, column) -> key map.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN    = 2'd0;
  localparam state_t CONFIRM = 2'd1;
  localparam state_t HELD    = 2'd2;

  // Key indices: 0..9 are the digits themselves.
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_SHARP = 4'd11;

  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'd0;
        default: return KEY_SHARP;
      endcase
    end
    return ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
  endfunction

  // True when exactly one active-low row line is asserted.
  function automatic logic one_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    case (r)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for asynchronous pin inputs; idles at all-ones so
// released pulled-up lines read as inactive straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_reg <= '1;
      q_reg    <= '1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: strobes columns, debounces the synchronised rows
// and emits one registered single-cycle pulse per accepted key press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_CYCLES       = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] keypad,
  output logic       sharp,
  output logic       star,
  output logic       busy
);

  localparam int DW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam int BW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_SAMPLES - 1);

  logic [3:0]    row_s;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  state_t        state_reg;
  logic [BW-1:0] db_reg;
  logic [1:0]    key_row_reg;
  logic [11:0]   pulse_reg;

  logic       sample;
  logic       valid;
  logic       row_match;
  logic [1:0] col_next;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  assign sample    = (dwell_reg == DWELL_LAST);
  assign valid     = one_low(row_s);
  assign row_match = (row_s == ~(4'b0001 << key_row_reg));
  assign col_next  = (col_idx_reg == 2'd2) ? 2'd0 : col_idx_reg + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_reg   <= '0;
      col_idx_reg <= 2'd0;
      state_reg   <= SCAN;
      db_reg      <= '0;
      key_row_reg <= 2'd0;
      pulse_reg   <= '0;
    end else begin
      pulse_reg <= '0;
      dwell_reg <= sample ? '0 : dwell_reg + 1'b1;
      if (sample) begin
        case (state_reg)
          SCAN: begin
            if (valid) begin
              key_row_reg <= low_index(row_s);
              db_reg      <= '0;
              state_reg   <= CONFIRM;
            end else begin
              col_idx_reg <= col_next;
            end
          end
          CONFIRM: begin
            if (!row_match) begin
              state_reg   <= SCAN;
              col_idx_reg <= col_next;
            end else if (db_reg == DB_LAST) begin
              pulse_reg <= 12'b1 << key_map(key_row_reg, col_idx_reg);
              db_reg    <= '0;
              state_reg <= HELD;
            end else begin
              db_reg <= db_reg + 1'b1;
            end
          end
          HELD: begin
            // Column stays frozen, so other columns' keys cannot be seen here.
            if (row_s != 4'hF) begin
              db_reg <= '0;
            end else if (db_reg == DB_LAST) begin
              db_reg      <= '0;
              state_reg   <= SCAN;
              col_idx_reg <= col_next;
            end else begin
              db_reg <= db_reg + 1'b1;
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign col    = ~(3'b001 << col_idx_reg);
  assign keypad = pulse_reg[9:0];
  assign star   = pulse_reg[KEY_STAR];
  assign sharp  = pulse_reg[KEY_SHARP];
  assign busy   = (state_reg != SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// column strobes; directed timing sequences plus randomized presses.
module tb_keypad_scanner;

  localparam int COLC = 4;
  localparam int DBS  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [2:0] col;
  logic [9:0] keypad;
  logic       sharp;
  logic       star;
  logic       busy;

  logic [11:0] pressed;
  int cyc = 0;
  int c0 = 0;
  int checks = 0;
  int errors = 0;
  int excl_viol = 0;
  int log_cyc[$];
  int log_code[$];

  typedef struct {
    int         k;
    logic [2:0] col_exp;
    logic       busy_exp;
  } vec_t;
  vec_t tbl[8];

  keypad_scanner #(.COL_CYCLES(COLC), .DEBOUNCE_SAMPLES(DBS)) dut (
    .clk    (clk),
    .rst    (rst),
    .row    (row),
    .col    (col),
    .keypad (keypad),
    .sharp  (sharp),
    .star   (star),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key code -> position: digits 1..9 row-major, then * 0 # on the bottom row.
  function automatic logic [3:0] pins(input logic [11:0] m, input logic [2:0] c);
    logic [3:0] r;
    int rr;
    int cc;
    r = 4'hF;
    for (int k = 0; k < 12; k++) begin
      if (m[k]) begin
        if (k >= 1 && k <= 9) begin
          rr = (k - 1) / 3;
          cc = (k - 1) % 3;
        end else begin
          rr = 3;
          cc = (k == 10) ? 0 : ((k == 0) ? 1 : 2);
        end
        if (!c[cc]) r[rr] = 1'b0;
      end
    end
    return r;
  endfunction

  assign row = pins(pressed, col);

  always @(negedge clk) begin
    int n;
    n = $countones({star, sharp, keypad});
    if (n > 1) excl_viol++;
    else if (n == 1) begin
      log_cyc.push_back(cyc);
      log_code.push_back(sharp ? 11 : (star ? 10 : $clog2(keypad)));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic at(input int k);
    while (cyc < c0 + k) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    log_cyc.delete();
    log_code.delete();
  endtask

  function automatic logic [11:0] km(input int code);
    return 12'b1 << code;
  endfunction

  initial begin
    int old_c0;
    rst = 1'b0;
    pressed = '0;
    tbl[0] = '{0,  3'b110, 1'b0};
    tbl[1] = '{3,  3'b110, 1'b0};
    tbl[2] = '{4,  3'b101, 1'b0};
    tbl[3] = '{7,  3'b101, 1'b0};
    tbl[4] = '{8,  3'b011, 1'b0};
    tbl[5] = '{11, 3'b011, 1'b0};
    tbl[6] = '{12, 3'b110, 1'b0};
    tbl[7] = '{15, 3'b110, 1'b0};
    @(negedge clk);

    // Reset state and free-running column scan.
    repeat (5) @(negedge clk);
    check("rst_col", col, 3'b110);
    check("rst_keypad", keypad, 0);
    check("rst_sharp", sharp, 0);
    check("rst_star", star, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      at(tbl[i].k);
      check($sformatf("scan_col_k%0d", tbl[i].k), col, tbl[i].col_exp);
      check($sformatf("scan_busy_k%0d", tbl[i].k), busy, tbl[i].busy_exp);
    end

    // Clean press of 5: first valid sample at k=7, pulse at k=20.
    do_reset(5);
    pressed = km(5);
    at(7);   check("p5_busy_before", busy, 0);
    at(8);   check("p5_busy_rise", busy, 1);
    at(20);  check("p5_keypad", keypad, 10'b0000100000);
    at(21);  check("p5_keypad_after", keypad, 0);
    at(100); pressed = '0;
    at(111); check("p5_busy_hold", busy, 1);
    at(112); check("p5_busy_fall", busy, 0);
    at(140);
    check("p5_count", log_code.size(), 1);
    if (log_code.size() >= 1) begin
      check("p5_code", log_code[0], 5);
      check("p5_time", log_cyc[0] - c0, 20);
    end

    // Bouncing 9: enters CONFIRM at k=11, aborts at k=15, accepted at k=27.
    do_reset(5);
    for (int k = 3; k < 23; k++) begin
      at(k);
      pressed = (((k - 3) / 3) % 2 == 0) ? km(9) : 12'd0;
    end
    at(23);  pressed = km(9);
    at(80);  pressed = '0;
    at(120);
    check("b9_count", log_code.size(), 1);
    if (log_code.size() >= 1) begin
      check("b9_code", log_code[0], 9);
      check("b9_time", log_cyc[0] - c0, 40);
    end

    // # then *.
    do_reset(5);
    pressed = km(11);
    at(40);  pressed = '0;
    at(70);  pressed = km(10);
    at(120); pressed = '0;
    at(160);
    check("hs_count", log_code.size(), 2);
    if (log_code.size() >= 2) begin
      check("hs_sharp_code", log_code[0], 11);
      check("hs_sharp_time", log_cyc[0] - c0, 24);
      check("hs_star_code", log_code[1], 10);
      check("hs_star_time", log_cyc[1] - c0, 92);
    end

    // Second key while held, then two rows low in one column.
    do_reset(5);
    pressed = km(1);
    at(30);  pressed = km(1) | km(3);
    at(60);  pressed = '0;
    at(80);  pressed = km(4) | km(7);
    at(130); pressed = '0;
    at(170);
    check("gh_count", log_code.size(), 1);
    if (log_code.size() >= 1) begin
      check("gh_code", log_code[0], 1);
      check("gh_time", log_cyc[0] - c0, 16);
    end

    // Reset while 0 is held: cleared, then reported once more.
    do_reset(5);
    old_c0 = c0;
    pressed = km(0);
    at(40);  check("rh_busy_held", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rh_busy_cleared", busy, 0);
    check("rh_col_cleared", col, 3'b110);
    check("rh_keypad_cleared", keypad, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    at(60);  pressed = '0;
    at(100);
    check("rh_count", log_code.size(), 2);
    if (log_code.size() >= 2) begin
      check("rh_first_code", log_code[0], 0);
      check("rh_first_time", log_cyc[0] - old_c0, 20);
      check("rh_second_code", log_code[1], 0);
      check("rh_second_time", log_cyc[1] - c0, 20);
    end

    // Random presses: each press yields exactly one event of its key, no
    // earlier than the minimum debounce latency and not after release.
    for (int it = 0; it < 30; it++) begin
      int key;
      int gap;
      int hold;
      int bounce;
      int n0;
      int tstart;
      int trel;
      key    = $urandom_range(0, 11);
      gap    = $urandom_range(20, 40);
      hold   = $urandom_range(40, 80);
      bounce = $urandom_range(0, 6);
      repeat (gap) @(negedge clk);
      n0 = log_code.size();
      tstart = cyc;
      for (int b = 0; b < bounce; b++) begin
        pressed = ($urandom_range(0, 1) == 1) ? km(key) : 12'd0;
        @(negedge clk);
      end
      pressed = km(key);
      repeat (hold) @(negedge clk);
      pressed = '0;
      trel = cyc;
      repeat (20) @(negedge clk);
      check($sformatf("rnd%0d_count", it), log_code.size() - n0, 1);
      if (log_code.size() == n0 + 1) begin
        check($sformatf("rnd%0d_code", it), log_code[n0], key);
        check($sformatf("rnd%0d_window", it),
              int'(log_cyc[n0] >= tstart + DBS * COLC + 1 && log_cyc[n0] <= trel + 2), 1);
      end
    end

    @(negedge clk);
    check("exclusive_outputs", excl_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
